pipeio_uart_tx: RTL

- Memory-mapped UART transmitter peripheral for the pipelined MIPS computer.
- Acts as the responder end of the MEM-stage I/O bus; the CPU store/load path is the initiator.
- The CPU writes bytes into a TX FIFO and polls a status word. The block serialises the bytes as 8N1 frames on `txd`.
- Sits beside the existing in/out ports in the MEM-stage I/O decode.

---
 rtl/pipeio_uart_tx.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeio_uart_tx.sv
// MEM-stage memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame.
module pipeio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_00C0,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  output logic [31:0] io_rdata,
  output logic        txd,
  output logic        tx_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          txd_q, txd_n;
  logic          irq_q;
  logic          ovf;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic [7:0]    head;

  logic hit, sel_tx, sel_st;
  logic push, pop, accept;
  logic full, empty, tick;
  logic ovf_set, ovf_clr;
  logic [4:0]  cnt5;
  logic [31:0] status;
  logic        par_flag;
  logic        unused;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_n;
  assign par_flag = 1'b1;
`else
  assign par_flag = 1'b0;
`endif

  assign unused = ^{io_addr[1:0], io_wdata[31:8]};

  assign hit    = io_addr[31:3] == BASE_ADDR[31:3];
  assign sel_tx = hit & ~io_addr[2];
  assign sel_st = hit & io_addr[2];

  assign full  = count == CFULL;
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  assign tick  = timer == TMAX;

  // A full FIFO still takes a byte when the head leaves on the same edge.
  assign push    = sel_tx & io_we;
  assign accept  = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign ovf_clr = sel_st & io_we & io_wdata[3];

  always_comb begin
    count_n = count;
    unique case ({accept, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n = state;
    timer_n = timer + TW'(1);
    bit_n   = bit_idx;
    shift_n = shift;
    txd_n   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    unique case (state)
      S_IDLE: begin
        timer_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          txd_n   = 1'b0;
          state_n = S_START;
`ifdef UART_TX_PARITY_EN
          par_n   = ^head;
`endif
        end
      end
      S_START: begin
        if (tick) begin
          timer_n = '0;
          txd_n   = shift[0];
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par_q;
            state_n = S_PAR;
`else
            txd_n   = 1'b1;
            state_n = S_STOP;
`endif
          end else begin
            shift_n = {1'b0, shift[7:1]};
            txd_n   = shift[1];
            bit_n   = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          timer_n = '0;
          txd_n   = 1'b1;
          state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          timer_n = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            txd_n   = 1'b0;
            state_n = S_START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^head;
`endif
          end else begin
            txd_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        timer_n = '0;
        txd_n   = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd_q   <= 1'b1;
      irq_q   <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      txd_q   <= txd_n;
      irq_q   <= (count_n == '0) &&
                 (state_n == S_IDLE);
      count   <= count_n;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= io_wdata[7:0];
  end

  assign cnt5   = 5'(count);
  assign status = {22'd0, par_flag, cnt5, ovf,
                   state != S_IDLE, empty, full};

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      sel_st:  io_rdata = status;
      default: io_rdata = '0;
    endcase
  end

  assign txd    = txd_q;
  assign tx_irq = irq_q;

endmodule
